fp32_acc_seq: RTL and testbench
===============================

Name: fp32_acc_seq

Overview:
- Sequencer directly upstream of the FP32 add node (registered-output adder with one-hot ctrl: 100 = pass ain, 010 = pass bin, 001 = ain+bin, 000 = zero).
- Accepts a job length and a valid/ready stream of FP32 operands.
- Drives the node's ain/bin/ctrl so the node's output register accumulates the sum, then presents the final sum on a valid/ready result port.
- Adder arithmetic stays in the node; this block owns sequencing, feedback routing and handshakes.

Parameters:
- LEN_W, 8, width of job length and remaining-element counter (max job 2^LEN_W-1 elements).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  job start request; sampled only in IDLE.
- len  input  LEN_W  element count for the job; sampled with start.
- busy  output  1  high whenever state != IDLE.
- in_data  input  32  FP32 operand.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready at clock edge.
- add_ain  output  32  to node ain; always equals in_data.
- add_bin  output  32  to node bin; always equals add_out (combinational feedback).
- add_ctrl  output  3  to node ctrl, one-hot or 000.
- add_out  input  32  node registered output (1-cycle latency).
- res_data  output  32  final sum; equals add_out.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumed when res_valid & res_ready at clock edge.

Behaviour:
- State machine: IDLE, CLEAR, ACCUM, DONE. Registers: state, cnt[LEN_W], first (1 bit). All outputs are combinational from state, first, in_valid and ports.
- Reset (rst_n=0 at edge): state=IDLE, cnt=0, first=0. Resulting outputs: busy=0, in_ready=0, res_valid=0, add_ctrl=010.
- Reset mid-job aborts the job with no result. The node shares rst_n; its output is not relied upon after reset.
- IDLE: in_ready=0, res_valid=0, add_ctrl=010 (hold).
  - start & len!=0 -> ACCUM, cnt=len, first=1.
  - start & len==0 -> CLEAR.
- CLEAR (one cycle): add_ctrl=000, so the node output becomes 0. -> DONE.
- ACCUM: in_ready=1.
  - in_valid=1: add_ctrl = first ? 100 : 001. On the edge: cnt=cnt-1, first=0. If cnt==1 at accept -> DONE.
  - in_valid=0 (bubble): add_ctrl=010 so the node holds the partial sum; no counter change.
- DONE: in_ready=0, res_valid=1, add_ctrl=010. res_data = add_out, which is the final sum because the node registered the last accept on the transition edge. res_valid & res_ready -> IDLE.
- Throughput: one operand per cycle. Latency from last accept to res_valid is 1 cycle.
- start outside IDLE is ignored; len is sampled only on the IDLE start edge.
- No combinational loop: add_out -> add_bin -> node adder -> node register.
- add_ctrl is never 000 except in CLEAR, and never multi-hot.
- cnt never wraps: the decrement occurs only in ACCUM with cnt>=1.

Test Plan:
- len=3; 0x3F800000, 0x40000000, 0x40400000 back-to-back, start at cycle 0 -> accepts at cycles 1-3 with add_ctrl 100, 001, 001; res_valid=1 at cycle 4 with res_data=0x40C00000.
- Same job with in_valid pattern 1,0,0,1,0,1 -> add_ctrl=010 on each bubble; result 0x40C00000; in_ready stays 1 throughout ACCUM.
- len=0 start -> one CLEAR cycle with add_ctrl=000, then DONE with res_data=0x00000000; no operand accepted.
- len=1, operand 0xC0200000 -> single 100 cycle; res_data=0xC0200000. Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, and start pulses during DONE are ignored.
- rst_n=0 for one edge after 2 of 4 operands accepted -> next cycle busy=0, in_ready=0, add_ctrl=010. New len=2 job with 0x3F800000, 0x3F800000 -> res_data=0x40000000.
- len=255 (max with LEN_W=8), all operands 0x3F800000 -> exactly 255 accepts; res_data=0x437F0000 (255.0); in_ready=0 after the 255th accept.

Source files
------------

// File: rtl/fp32_acc_seq.sv
// fp32_acc_seq: sequencer in front of a registered FP32 add node.
// Routes operands into the node (ain), feeds the node output back (bin),
// and picks the node operation so its output register accumulates a job.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; node holds its value
// CLEAR | zero-length job; node output forced to 0 for one cycle
// ACCUM | accepting operands; first one loads, later ones add
// DONE  | node output is the final sum; offered on the result port
module fp32_acc_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_ain,
    output logic [31:0]      add_bin,
    output logic [2:0]       add_ctrl,
    input  logic [31:0]      add_out,
    output logic [31:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0]       CTRL_PASS_A = 3'b100;
    localparam logic [2:0]       CTRL_HOLD   = 3'b010;
    localparam logic [2:0]       CTRL_ADD    = 3'b001;
    localparam logic [2:0]       CTRL_ZERO   = 3'b000;
    localparam logic [LEN_W-1:0] CNT_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ZERO    = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_first;
    logic             w_first_nxt;
    logic             w_accept;

    // Data paths are pure wiring: operand straight in, node output fed back
    // and exposed as the result. The node register breaks the loop.
    assign add_ain  = in_data;
    assign add_bin  = add_out;
    assign res_data = add_out;
    assign w_accept = (r_state == S_ACCUM) && in_valid;

    // State, remaining count and first-operand flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
        end
    end

    // Next-state logic and all handshake / node-control outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        busy        = 1'b1;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        add_ctrl    = CTRL_HOLD;

        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (len != CNT_ZERO) begin
                        w_state_nxt = S_ACCUM;
                        w_cnt_nxt   = len;
                        w_first_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                add_ctrl    = CTRL_ZERO;
                w_state_nxt = S_DONE;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    // First operand overwrites whatever the node held, so no
                    // separate clear cycle is needed for non-empty jobs.
                    add_ctrl    = r_first ? CTRL_PASS_A : CTRL_ADD;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    w_first_nxt = 1'b0;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp32_acc_seq.sv
// Directed bench for fp32_acc_seq with a behavioural FP32 add node.
module tb_fp32_acc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] add_ain;
    logic [31:0] add_bin;
    logic [2:0]  add_ctrl;
    logic [31:0] add_out;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp32_acc_seq #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_ain(add_ain), .add_bin(add_bin), .add_ctrl(add_ctrl),
        .add_out(add_out), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    // FP32 <-> real for normal numbers and zero (enough for these vectors).
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real     a;
        int      e;
        longint  frac;
        logic    s;
        logic [7:0] ex;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        frac = longint'((a - 1.0) * 8388608.0);
        ex   = 8'(e + 127);
        return {s, ex, frac[22:0]};
    endfunction

    // Node model: registered adder, shares the reset.
    always @(posedge clk) begin
        if (!rst_n) add_out <= 32'd0;
        else begin
            case (add_ctrl)
                3'b100:  add_out <= add_ain;
                3'b010:  add_out <= add_bin;
                3'b001:  add_out <= r2f(f2r(add_ain) + f2r(add_bin));
                default: add_out <= 32'd0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; len = 0; in_valid = 0; in_data = 32'd0; res_ready = 0;
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1; len = l;
        step();
        start = 0; len = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        in_valid = 1; in_data = 32'h12345678;
        step(); step();
        #1;
        n_cmp++;
        if ({busy, in_ready, res_valid, add_ctrl} !== 6'b000_010) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy/in_ready/res_valid/ctrl=%b required 000010",
                     {busy, in_ready, res_valid, add_ctrl});
        end
        n_cmp++;
        if (add_ain !== 32'h12345678) begin
            n_bad++; $display("FAIL ain_passthru: got %h required 12345678", add_ain);
        end
        rst_n = 1; in_valid = 0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        logic [2:0]  ctl [3] = '{3'b100, 3'b001, 3'b001};
        start_job(8'd3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = ops[i];
            #1;
            n_cmp++;
            if (add_ctrl !== ctl[i] || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_ctrl[%0d]: got ctrl=%b ready=%b required ctrl=%b ready=1",
                         i, add_ctrl, in_ready, ctl[i]);
            end
            step();
        end
        in_valid = 0;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h40C00000 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: got valid=%b data=%h ready=%b required 1 40c00000 0",
                     res_valid, res_data, in_ready);
        end
        res_ready = 1;
        step();
        res_ready = 0;
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_release: got busy=%b valid=%b required 0 0", busy, res_valid);
        end
    endtask

    task automatic test_bubbles();
        logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ops [6] = '{32'h3F800000, 32'h0, 32'h0, 32'h40000000, 32'h0, 32'h40400000};
        logic [2:0]  ctl [6] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b010, 3'b001};
        start_job(8'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_data  = pat[i] ? ops[i] : 32'hDEADBEEF;
            #1;
            n_cmp++;
            if (add_ctrl !== ctl[i] || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL bubble_ctrl[%0d]: got ctrl=%b ready=%b required ctrl=%b ready=1",
                         i, add_ctrl, in_ready, ctl[i]);
            end
            step();
        end
        in_valid = 0;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h40C00000) begin
            n_bad++;
            $display("FAIL bubble_result: got valid=%b data=%h required 1 40c00000", res_valid, res_data);
        end
        res_ready = 1; step(); res_ready = 0;
    endtask

    task automatic test_zero_len();
        in_valid = 1; in_data = 32'h3F800000;
        start_job(8'd0);
        #1;
        n_cmp++;
        if (add_ctrl !== 3'b000 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_cycle: got ctrl=%b ready=%b busy=%b required 000 0 1",
                     add_ctrl, in_ready, busy);
        end
        step();
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h00000000 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_result: got valid=%b data=%h ready=%b required 1 00000000 0",
                     res_valid, res_data, in_ready);
        end
        in_valid = 0;
        res_ready = 1; step(); res_ready = 0;
    endtask

    task automatic test_single_hold();
        start_job(8'd1);
        in_valid = 1; in_data = 32'hC0200000;
        #1;
        n_cmp++;
        if (add_ctrl !== 3'b100) begin
            n_bad++; $display("FAIL single_ctrl: got %b required 100", add_ctrl);
        end
        step();
        in_valid = 0; in_data = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            start = 1; len = 8'd5;
            #1;
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 32'hC0200000 || add_ctrl !== 3'b010) begin
                n_bad++;
                $display("FAIL hold_result[%0d]: got valid=%b data=%h ctrl=%b required 1 c0200000 010",
                         i, res_valid, res_data, add_ctrl);
            end
            step();
        end
        start = 0; len = 0;
        res_ready = 1; step(); res_ready = 0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL hold_release: got busy=%b ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        start_job(8'd4);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = 32'h40000000; step();
        end
        in_valid = 0;
        rst_n = 0; step(); rst_n = 1;
        #1;
        n_cmp++;
        if ({busy, in_ready, res_valid, add_ctrl} !== 6'b000_010) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy/in_ready/res_valid/ctrl=%b required 000010",
                     {busy, in_ready, res_valid, add_ctrl});
        end
        step();
        start_job(8'd2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = 32'h3F800000; step();
        end
        in_valid = 0;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h40000000) begin
            n_bad++;
            $display("FAIL post_abort_result: got valid=%b data=%h required 1 40000000", res_valid, res_data);
        end
        res_ready = 1; step(); res_ready = 0;
    endtask

    task automatic test_max_len();
        int accepts = 0;
        int cycles  = 0;
        start_job(8'd255);
        in_data = 32'h3F800000;
        while (!res_valid && cycles < 400) begin
            in_valid = 1;
            #1;
            if (in_valid && in_ready) accepts++;
            step();
            cycles++;
        end
        in_valid = 0;
        #1;
        n_cmp++;
        if (accepts !== 255) begin
            n_bad++; $display("FAIL max_accepts: got %0d required 255", accepts);
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h437F0000 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL max_result: got valid=%b data=%h ready=%b required 1 437f0000 0",
                     res_valid, res_data, in_ready);
        end
        res_ready = 1; step(); res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_zero_len();
        test_single_hold();
        test_reset_abort();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
